wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Arbitrates execute-stage results onto the scoreboard's NR_WB write-back ports.
- Sources are the execute-stage functional units: alu_0, alu_1, branch, mult, lsu and csr.
- Each source has a 1-entry hold buffer; a round-robin selector maps held entries onto ports.
- Sits between the execute stage outputs and the scoreboard write-back inputs, and back-pressures FUs when ports are oversubscribed.

Parameters:
- NR_SRC, 6, number of result sources; index order is alu_0, alu_1, branch, mult, lsu, csr.
- NR_WB, 4, number of scoreboard write-back ports; legal range 1..NR_SRC.
- DATA_W, 64, result width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- flush_i  in  1  discard all held and incoming results.
- src_valid_i  in  NR_SRC  source result valid.
- src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  scoreboard entry of the result.
- src_result_i  in  NR_SRC x DATA_W  result data.
- src_exception_i  in  NR_SRC x exception_t  exception of the result.
- src_ready_o  out  NR_SRC  hold buffer can capture this cycle.
- wb_valid_o  out  NR_WB  port carries a result.
- wb_trans_id_o  out  NR_WB x TRANS_ID_BITS  port trans id.
- wb_data_o  out  NR_WB x DATA_W  port data.
- wb_ex_o  out  NR_WB x exception_t  port exception.
- wb_ready_i  in  NR_WB  scoreboard accepts the port this cycle.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low.
- Reset: all hold valids = 0 and rr_q = 0.
  - Hence wb_valid_o = 0, wb_trans_id_o/wb_data_o/wb_ex_o = '0, and src_ready_o = all 1s.
- Capture: the hold register for source s loads on a clock edge when src_valid_i[s] & src_ready_o[s] & ~flush_i.
- Ready: src_ready_o[s] = ~hold_v[s] | rel[s], where rel[s] means "held entry released this cycle".
  - Same-cycle release and capture is allowed, so a source can write back every cycle.
- Latency: 1 cycle minimum from src_valid_i to wb_valid_o. The block has no combinational bypass.
- Selection: scan the held entries starting at index rr_q, wrapping modulo NR_SRC.
  - The k-th held entry found drives port k, for k < NR_WB.
  - Ports with no assigned entry have wb_valid_o = 0 and all payload fields = 0.
- Valid/ready independence: wb_valid_o and the port payload never depend on wb_ready_i.
- Release: rel[s] = 1 when s is assigned to port k and wb_ready_i[k] = 1. A released entry is cleared at the edge unless it is re-captured.
- Unaccepted ports: an entry assigned to a port with wb_ready_i = 0 stays held.
  - It is re-arbitrated next cycle, possibly onto a different port.
  - It is never duplicated or dropped.
- RR pointer update:
  - If any entry is released, rr_q becomes (highest-scan-order released index + 1) mod NR_SRC.
  - Otherwise rr_q holds.
  - Under continuous contention, starvation is bounded to ceil(NR_SRC/NR_WB) cycles when all ports are ready.
- Flush: takes priority over every other update.
  - At the next edge all hold valids clear and rr_q = 0.
  - Same-cycle captures are dropped.
  - Outputs in the flush cycle are still driven from current state, and the scoreboard ignores them.
- Empty case: if no source holds an entry, all wb_valid_o = 0.
- Full case (all NR_SRC held, NR_WB < NR_SRC): exactly NR_WB entries are presented. The remaining sources see src_ready_o = 0.
- Protocol: a source with src_valid_i = 1 and src_ready_o = 0 must hold its valid and payload stable.
  - Assertion: no two ports carry the same trans id in one cycle.
- Reset mid-operation: held entries are discarded, identical to the reset state.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined, adds output stall_cnt_o (out, 32).
  - Saturating counter, incremented each cycle in which at least one held entry is not released: unassigned, or its port not ready.
  - Cleared by reset, not by flush.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- ariane_pkg additions:
  - wb_entry_t struct {trans_id, data, ex}.
  - NR_WB_PORTS constant.
  - Source index localparams (WB_SRC_ALU0 .. WB_SRC_CSR).
- Sub-module wb_rr_pick, combinational.
  - Inputs: NR_SRC request mask and the start pointer.
  - Outputs: per-port one-hot source selection and per-port valid.

Test Plan:
1. After reset, src_valid_i[0] = 1 for one cycle with trans 3, data 0xDEAD, all ready -> wb_valid_o[0] = 1 with trans 3 and data 0xDEAD on the next cycle; other ports invalid; rr_q = 1.
2. All 6 sources valid once, all ports ready -> cycle 1 ports 0-3 carry sources 0-3; cycle 2 ports 0-1 carry sources 4, 5; src_ready_o[5:4] = 0 in cycle 1; rr_q ends at 0.
3. One entry, wb_ready_i[0] = 0 for 3 cycles then 1 -> the same entry is presented for 4 cycles, written back exactly once, and src_ready_o stays low until the release cycle.
4. Source 1 valid every cycle for 8 cycles with incrementing data 1..8, all ready -> 8 consecutive write-backs in order, 1-cycle latency, src_ready_o[1] stays 1.
5. Three entries held, flush_i = 1 together with a new src_valid_i[2] -> next cycle all wb_valid_o = 0 and rr_q = 0; the source 2 result never appears.
6. With WB_ARB_PERF_EN, NR_WB = 4, 6 sources valid every cycle for 10 cycles, all ready -> stall_cnt_o = 10 after the run; a flush does not clear it.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the execute-stage write-back arbiter.
// Holds the result entry layout, the write-back port count and the source index map.
package wb_arbiter_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned NR_WB_PORTS   = 4;

  // Source index order on the arbiter request vector.
  localparam int unsigned WB_SRC_ALU0   = 0;
  localparam int unsigned WB_SRC_ALU1   = 1;
  localparam int unsigned WB_SRC_BRANCH = 2;
  localparam int unsigned WB_SRC_MULT   = 3;
  localparam int unsigned WB_SRC_LSU    = 4;
  localparam int unsigned WB_SRC_CSR    = 5;
  localparam int unsigned WB_NR_SRC     = 6;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    exception_t               ex;
  } wb_entry_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: walks the request mask from start_i (wrapping) and
// assigns the k-th request found to port k, for the first NR_WB requests.
module wb_rr_pick #(
  parameter int unsigned NR_SRC = 6,
  parameter int unsigned NR_WB  = 4,
  parameter int unsigned PTR_W  = 3
) (
  input  logic [NR_SRC-1:0]             req_i,
  input  logic [PTR_W-1:0]              start_i,
  output logic [NR_WB-1:0][NR_SRC-1:0]  sel_o,
  output logic [NR_WB-1:0]              valid_o
);

  localparam int unsigned PORT_W = (NR_WB > 1) ? $clog2(NR_WB) : 1;

  int unsigned        pos;
  int unsigned        port_cnt;
  logic [PTR_W-1:0]   idx;
  logic [PORT_W-1:0]  port_idx;

  always_comb begin
    sel_o    = '0;
    valid_o  = '0;
    pos      = 0;
    port_cnt = 0;
    idx      = '0;
    port_idx = '0;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      pos = 32'(start_i) + i;
      if (pos >= NR_SRC) begin
        pos = pos - NR_SRC;
      end
      idx      = pos[PTR_W-1:0];
      port_idx = port_cnt[PORT_W-1:0];
      if (req_i[idx] && (port_cnt < NR_WB)) begin
        sel_o[port_idx][idx] = 1'b1;
        valid_o[port_idx]    = 1'b1;
        port_cnt             = port_cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one hold buffer per execute-stage source, round-robin onto NR_WB ports.
// Optional WB_ARB_PERF_EN adds stall_cnt_o, a saturating count of cycles with a held entry left behind.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_SRC = WB_NR_SRC,
  parameter int unsigned NR_WB  = NR_WB_PORTS,
  parameter int unsigned DATA_W = XLEN
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NR_SRC-1:0]                   src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0] src_trans_id_i,
  input  logic [NR_SRC-1:0][DATA_W-1:0]       src_result_i,
  input  exception_t [NR_SRC-1:0]             src_exception_i,
  output logic [NR_SRC-1:0]                   src_ready_o,
  output logic [NR_WB-1:0]                    wb_valid_o,
  output logic [NR_WB-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB-1:0][DATA_W-1:0]        wb_data_o,
  output exception_t [NR_WB-1:0]              wb_ex_o,
  input  logic [NR_WB-1:0]                    wb_ready_i
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                         stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic [NR_SRC-1:0]            hold_v_q, hold_v_d;
  wb_entry_t [NR_SRC-1:0]       hold_q, hold_d;
  logic [PTR_W-1:0]             rr_q, rr_d;

  logic [NR_WB-1:0][NR_SRC-1:0] sel;
  logic [NR_WB-1:0]             port_v;
  wb_entry_t [NR_WB-1:0]        port_entry;
  logic [NR_SRC-1:0]            rel;
  logic [NR_SRC-1:0]            cap;
  logic [PTR_W-1:0]             last_rel;

  wb_rr_pick #(
    .NR_SRC (NR_SRC),
    .NR_WB  (NR_WB),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req_i   (hold_v_q),
    .start_i (rr_q),
    .sel_o   (sel),
    .valid_o (port_v)
  );

  // One-hot OR-mux; unassigned ports fall out as all-zero payload.
  always_comb begin
    port_entry = '0;
    rel        = '0;
    last_rel   = '0;
    for (int unsigned k = 0; k < NR_WB; k++) begin
      for (int unsigned s = 0; s < NR_SRC; s++) begin
        if (sel[k][s]) begin
          port_entry[k] = port_entry[k] | hold_q[s];
          if (wb_ready_i[k]) begin
            last_rel = PTR_W'(s);
          end
        end
      end
      if (port_v[k] && wb_ready_i[k]) begin
        rel = rel | sel[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NR_WB; k++) begin
      wb_valid_o[k]    = port_v[k];
      wb_trans_id_o[k] = port_entry[k].trans_id;
      wb_data_o[k]     = port_entry[k].data;
      wb_ex_o[k]       = port_entry[k].ex;
    end
  end

  assign src_ready_o = ~hold_v_q | rel;
  assign cap         = src_valid_i & src_ready_o & {NR_SRC{~flush_i}};

  always_comb begin
    hold_d = hold_q;
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      if (cap[s]) begin
        hold_d[s].trans_id = src_trans_id_i[s];
        hold_d[s].data     = src_result_i[s];
        hold_d[s].ex       = src_exception_i[s];
      end
    end
  end

  // Ports are filled in scan order, so the last released port holds the furthest released source.
  always_comb begin
    hold_v_d = (hold_v_q & ~rel) | cap;
    rr_d     = rr_q;
    if (|rel) begin
      rr_d = (last_rel == PTR_W'(NR_SRC - 1)) ? '0 : last_rel + 1'b1;
    end
    if (flush_i) begin
      hold_v_d = '0;
      rr_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_v_q <= '0;
      rr_q     <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_q     <= rr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|(hold_v_q & ~rel)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned a = 0; a < NR_WB; a++) begin
        for (int unsigned b = a + 1; b < NR_WB; b++) begin
          assert (!(wb_valid_o[a] && wb_valid_o[b] && (wb_trans_id_o[a] == wb_trans_id_o[b])));
        end
      end
    end
  end

endmodule
